// File: rtl/wb_pkg.sv
// Shared constants and FSM state encoding for the write buffer.
package wb_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 10;
  localparam int DW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side store/refill ports plus memory-side transaction ports of the write buffer.
interface write_buffer_if #(
  parameter int AW = wb_pkg::AW_DEF,
  parameter int DW = wb_pkg::DW_DEF
) ();

  logic          wr_req;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_data;
  logic          wb_full;
  logic          wb_empty;
  logic          rd_req;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          mem_req;
  logic          mem_WE;
  logic [AW-1:0] mem_Adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_adr, wr_data, rd_req, rd_adr, mem_ack, mem_rdata,
    output wb_full, wb_empty, rd_data, rd_valid, mem_req, mem_WE, mem_Adr, mem_wdata
  );

  modport master (
    output wr_req, wr_adr, wr_data, rd_req, rd_adr, mem_ack, mem_rdata,
    input  wb_full, wb_empty, rd_data, rd_valid, mem_req, mem_WE, mem_Adr, mem_wdata
  );

endinterface

// File: rtl/wb_fifo.sv
// Store FIFO: entry storage, head/tail pointers, occupancy count and flags.
// With WB_FORWARD_EN defined it also searches valid entries for the youngest address match.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_req,
  input  logic [AW-1:0] push_adr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
`ifdef WB_FORWARD_EN
  input  logic [AW-1:0] srch_adr,
  output logic          srch_hit,
  output logic [DW-1:0] srch_data,
`endif
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_adr,
  output logic [DW-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] adr_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop_ok;

  // A full buffer refuses the store even if the head leaves on the same edge.
  assign push      = push_req && !full;
  assign pop_ok    = pop && !empty;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_adr  = adr_mem[head_q];
  assign head_data = data_mem[head_q];

  always_ff @(posedge CLK) begin
    if (push) begin
      adr_mem[tail_q]  <= push_adr;
      data_mem[tail_q] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)   tail_q <= tail_q + 1'b1;
      if (pop_ok) head_q <= head_q + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    srch_hit  = 1'b0;
    srch_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (adr_mem[PW'(head_q + PW'(k))] == srch_adr)) begin
        srch_hit  = 1'b1;
        srch_data = data_mem[PW'(head_q + PW'(k))];
      end
    end
  end
`endif

endmodule

// File: rtl/write_buffer.sv
// Write buffer between cache controller and memory: queues stores, arbitrates refill reads.
// Optional WB_FORWARD_EN: refill reads that hit a buffered store are served from the buffer.
//
// state   | meaning
// ST_IDLE | no memory transaction; pick next job by priority
// ST_WR   | draining head store, waiting for mem_ack
// ST_RD   | refill read in flight, waiting for mem_ack
module write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  write_buffer_if.slave  bus
);

  wb_state_e     state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_adr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;

  logic          full;
  logic          empty;
  logic [AW-1:0] head_adr;
  logic [DW-1:0] head_data;
  logic          pop;
  logic          rd_take;
  logic          rd_ok;
`ifdef WB_FORWARD_EN
  logic          srch_hit;
  logic [DW-1:0] srch_data;
`endif

  assign pop     = (state_q == ST_WR) && bus.mem_ack;
  // The cache still holds rd_req during the rd_valid cycle; it must not start a second read.
  assign rd_take = bus.rd_req && !rd_valid_q;

`ifdef WB_FORWARD_EN
  assign rd_ok = !srch_hit;
`else
  assign rd_ok = empty;
`endif

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push_req (bus.wr_req),
    .push_adr (bus.wr_adr),
    .push_data(bus.wr_data),
    .pop      (pop),
`ifdef WB_FORWARD_EN
    .srch_adr (bus.rd_adr),
    .srch_hit (srch_hit),
    .srch_data(srch_data),
`endif
    .full     (full),
    .empty    (empty),
    .head_adr (head_adr),
    .head_data(head_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (full) begin
            state_q     <= ST_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_adr_q   <= head_adr;
            mem_wdata_q <= head_data;
          end else if (rd_take && rd_ok) begin
            state_q   <= ST_RD;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_adr_q <= bus.rd_adr;
          end
`ifdef WB_FORWARD_EN
          else if (rd_take) begin
            rd_data_q  <= srch_data;
            rd_valid_q <= 1'b1;
          end
`endif
          else if (!empty) begin
            state_q     <= ST_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_adr_q   <= head_adr;
            mem_wdata_q <= head_data;
          end
        end
        ST_WR: begin
          if (bus.mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        ST_RD: begin
          if (bus.mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            rd_data_q  <= bus.mem_rdata;
            rd_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_full   = full;
  assign bus.wb_empty  = empty;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_WE    = mem_we_q;
  assign bus.mem_Adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule
